// File: rtl/param_register_bank_pkg.sv
// Shared definitions for the parameterised register bank: default geometry
// and the controller state encoding.
package param_register_bank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/rb_read_port.sv
// One combinational read port: array mux with zero-register, clear blanking
// and same-cycle write forwarding.
module rb_read_port
  import param_register_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [DATA_W-1:0] mem_i [(1 << ADDR_W)],
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              blank_i,
  input  logic              byp_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // Blanking outranks the zero register, which outranks forwarding.
  always_comb begin
    rd_data_o = mem_i[rd_addr_i];
    if (blank_i) begin
      rd_data_o = {DATA_W{1'b0}};
    end else if ((ZERO_REG != 0) && (rd_addr_i == {ADDR_W{1'b0}})) begin
      rd_data_o = {DATA_W{1'b0}};
    end else if ((BYPASS != 0) && byp_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = mem_i[rd_addr_i];
    end
  end

endmodule

// File: rtl/param_register_bank.sv
// Multi-read-port register file with a sequential soft-clear engine that
// zeroes one entry per cycle while reporting busy.
module param_register_bank
  import param_register_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_fire;

  // A clear request in the same cycle takes priority over the write.
  assign wr_fire = (state_q == ST_IDLE) && wr_en && !clr_req &&
                   !((ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}}));

  // Controller next state: idle/clear sequencing and the completion pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Storage next state: one entry zeroed per clear cycle, else the write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (state_q == ST_CLEAR) begin
      mem_d[cnt_q] = {DATA_W{1'b0}};
    end else if (wr_fire) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d[wr_addr] = mem_q[wr_addr];
    end
  end

  // State, counter, pulse and storage flops, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_done = done_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    rb_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .mem_i    (mem_q),
      .rd_addr_i(rd_addr[g*ADDR_W +: ADDR_W]),
      .blank_i  (busy),
      .byp_en_i (wr_fire),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .rd_data_o(rd_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_param_register_bank.sv
// Randomised bench for param_register_bank against an array-based model,
// with one forwarding instance and one non-forwarding instance.
module tb_param_register_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic             wr_en, clr_req;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             busy, clr_done, busy_nb, clr_done_nb;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  int            m_idx;
  bit            m_done;

  always #5 clk = ~clk;

  param_register_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy), .clr_done(clr_done));

  param_register_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy_nb), .clr_done(clr_done_nb));

  // Expected read value of an address given the model and the current inputs.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (m_busy || a == 0) return '0;
    if (byp && wr_en && !clr_req && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 1'b0;
    m_idx  = 0;
    m_done = 1'b0;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; rd_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  // Advance the model by one rising edge using the present inputs, then clock.
  task automatic tick();
    bit nd;
    nd = 1'b0;
    if (reset) begin
      if (m_busy) begin
        m_mem[m_idx] = '0;
        m_idx++;
        if (m_idx == DEPTH) begin
          m_busy = 1'b0;
          nd = 1'b1;
        end
      end else if (clr_req) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end else if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr] = wr_data;
      end
      m_done = nd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(DEPTH - 1 - a));
      #1;
      for (int p = 0; p < NR; p++) begin
        vectors++;
        if (rd_data[p*DW +: DW] !== 32'h0 || rd_data_nb[p*DW +: DW] !== 32'h0) begin
          miscompares++;
          $display("FAIL reset_rd p%0d got=%h/%h exp=0", p, rd_data[p*DW +: DW], rd_data_nb[p*DW +: DW]);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || busy_nb !== 1'b0 || clr_done_nb !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags busy=%b done=%b exp 0 0", busy, clr_done);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    set_rd(0, 5'd5); set_rd(1, 5'd5);
    #1;
    for (int p = 0; p < NR; p++) begin
      vectors++;
      if (rd_data[p*DW +: DW] !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL wr_rd_r5 p%0d got=%h exp=deadbeef", p, rd_data[p*DW +: DW]);
      end
    end
    set_rd(0, 5'd6);
    #1;
    vectors++;
    if (rd_data[DW-1:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL wr_rd_r6 got=%h exp=0", rd_data[DW-1:0]);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    #1;
    vectors++;
    if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
      miscompares++;
      $display("FAIL zero_bypass got=%h/%h exp=0", rd_data, rd_data_nb);
    end
    tick();
    wr_en = 1'b0;
    #1;
    vectors++;
    if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
      miscompares++;
      $display("FAIL zero_after got=%h/%h exp=0", rd_data, rd_data_nb);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11110000;
    tick();
    wr_data = 32'hA5A5A5A5;
    set_rd(0, 5'd5); set_rd(1, 5'd7);
    #1;
    vectors++;
    if (rd_data[DW +: DW] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL bypass_on got=%h exp=a5a5a5a5", rd_data[DW +: DW]);
    end
    vectors++;
    if (rd_data_nb[DW +: DW] !== 32'h11110000) begin
      miscompares++;
      $display("FAIL bypass_off got=%h exp=11110000", rd_data_nb[DW +: DW]);
    end
    vectors++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF || rd_data_nb[DW-1:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_other got=%h/%h exp=deadbeef", rd_data[DW-1:0], rd_data_nb[DW-1:0]);
    end
    tick();
    wr_en = 1'b0;
    #1;
    vectors++;
    if (rd_data_nb[DW +: DW] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL bypass_commit got=%h exp=a5a5a5a5", rd_data_nb[DW +: DW]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en   = ($urandom_range(0, 2) != 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      clr_req = 1'b0;
      for (int p = 0; p < NR; p++)
        set_rd(p, ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1)));
      #1;
      for (int p = 0; p < NR; p++) begin
        vectors++;
        if (rd_data[p*DW +: DW] !== exp_rd(rd_addr[p*AW +: AW], 1'b1) ||
            rd_data_nb[p*DW +: DW] !== exp_rd(rd_addr[p*AW +: AW], 1'b0)) begin
          miscompares++;
          $display("FAIL rand_rd n%0d p%0d a=%0d got=%h/%h exp=%h/%h", n, p, rd_addr[p*AW +: AW],
                   rd_data[p*DW +: DW], rd_data_nb[p*DW +: DW],
                   exp_rd(rd_addr[p*AW +: AW], 1'b1), exp_rd(rd_addr[p*AW +: AW], 1'b0));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    for (int a = 1; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    for (int c = 0; c < DEPTH; c++) begin
      clr_req = 1'($urandom_range(0, 1));
      wr_en = 1'b1; wr_addr = AW'($urandom_range(1, DEPTH - 1)); wr_data = $urandom | 32'h1;
      set_rd(0, wr_addr); set_rd(1, AW'($urandom_range(0, DEPTH - 1)));
      #1;
      vectors++;
      if (busy !== m_busy || clr_done !== m_done || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL clr_busy c%0d busy=%b done=%b exp 1 0", c, busy, clr_done);
      end
      vectors++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
        miscompares++;
        $display("FAIL clr_rd c%0d got=%h exp=0", c, rd_data);
      end
      tick();
    end
    idle_inputs();
    #1;
    vectors++;
    if (busy !== 1'b0 || clr_done !== 1'b1 || clr_done_nb !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_done_pulse busy=%b done=%b exp 0 1", busy, clr_done);
    end
    tick();
    vectors++;
    if (clr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_done_width done=%b exp 0", clr_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a)); set_rd(1, AW'(a));
      #1;
      vectors++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0 || exp_rd(AW'(a), 1'b1) !== 32'h0) begin
        miscompares++;
        $display("FAIL clr_after a%0d got=%h exp=0", a, rd_data);
      end
    end
  endtask

  task automatic test_clr_wr_conflict();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    tick();
    clr_req = 1'b1; wr_data = 32'h55;
    tick();
    idle_inputs();
    for (int c = 0; c < DEPTH; c++) tick();
    set_rd(0, 5'd3);
    #1;
    vectors++;
    if (rd_data[DW-1:0] !== 32'h0 || clr_done !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_r3 got=%h done=%b exp=0 1", rd_data[DW-1:0], clr_done);
    end
  endtask

  task automatic test_clr_restart();
    tick();
    clr_req = 1'b1;
    for (int c = 0; c < DEPTH + 1; c++) tick();
    vectors++;
    if (clr_done !== 1'b1 || busy !== 1'b0 || m_done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_done busy=%b done=%b exp 0 1", busy, clr_done);
    end
    tick();
    vectors++;
    if (busy !== 1'b1 || clr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_busy busy=%b done=%b exp 1 0", busy, clr_done);
    end
    clr_req = 1'b0;
    for (int c = 0; c < DEPTH; c++) tick();
    vectors++;
    if (busy !== m_busy || clr_done !== m_done) begin
      miscompares++;
      $display("FAIL restart_end busy=%b done=%b exp %b %b", busy, clr_done, m_busy, m_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h1;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midclr_busy busy=%b exp 1", busy);
    end
    reset = 1'b0;
    model_reset();
    set_rd(0, 5'd20);
    #1;
    vectors++;
    if (rd_data[DW-1:0] !== 32'h0 || busy !== 1'b0 || clr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midclr_reset r20=%h busy=%b done=%b exp 0 0 0", rd_data[DW-1:0], busy, clr_done);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      vectors++;
      if (clr_done !== 1'b0 || busy !== 1'b0 || rd_data[DW-1:0] !== exp_rd(5'd20, 1'b1)) begin
        miscompares++;
        $display("FAIL midclr_after c%0d done=%b busy=%b r20=%h exp 0 0 0", c, clr_done, busy, rd_data[DW-1:0]);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_random();
    test_clear();
    test_clr_wr_conflict();
    test_clr_restart();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
